// File: rtl/mcdf_arbiter_if.sv
// MCDF arbiter channel and formatter bus.
// Master drives channels/config, slave is the arbiter.
interface mcdf_arbiter_if;
  logic        ch0_req;
  logic        ch1_req;
  logic        ch2_req;
  logic [31:0] ch0_data;
  logic [31:0] ch1_data;
  logic [31:0] ch2_data;
  logic        ch0_ack;
  logic        ch1_ack;
  logic        ch2_ack;
  logic [1:0]  cfg_prio0;
  logic [1:0]  cfg_prio1;
  logic [1:0]  cfg_prio2;
  logic [1:0]  cfg_len;
  logic        fmt_rdy;
  logic        fmt_val;
  logic [31:0] fmt_data;
  logic [1:0]  fmt_id;
  logic        fmt_sop;
  logic        fmt_eop;

  modport master (
    output ch0_req, ch1_req, ch2_req,
    output ch0_data, ch1_data, ch2_data,
    input  ch0_ack, ch1_ack, ch2_ack,
    output cfg_prio0, cfg_prio1, cfg_prio2,
    output cfg_len, fmt_rdy,
    input  fmt_val, fmt_data, fmt_id,
    input  fmt_sop, fmt_eop
  );

  modport slave (
    input  ch0_req, ch1_req, ch2_req,
    input  ch0_data, ch1_data, ch2_data,
    output ch0_ack, ch1_ack, ch2_ack,
    input  cfg_prio0, cfg_prio1, cfg_prio2,
    input  cfg_len, fmt_rdy,
    output fmt_val, fmt_data, fmt_id,
    output fmt_sop, fmt_eop
  );
endinterface

// File: rtl/mcdf_arbiter.sv
// MCDF 3-channel packet arbiter.
// Priority select, round-robin ties, fixed-length packets.
module mcdf_arbiter (
  input  logic           clk,
  input  logic           rst,
  mcdf_arbiter_if.slave  bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  logic [0:0] state_q;
  logic [1:0] grant_q;
  logic [1:0] last_q;
  logic [1:0] len_q;
  logic [5:0] cnt_q;

  logic [2:0]      req_v;
  logic [2:0][1:0] prio_v;
  logic [1:0]      min_p;
  logic [1:0]      win;
  logic [1:0]      cand;
  logic            found;
  logic            g_req;
  logic            val;
  logic            beat;
  logic [5:0]      last_beat;

  assign req_v  = {bus.ch2_req, bus.ch1_req, bus.ch0_req};
  assign prio_v = {bus.cfg_prio2, bus.cfg_prio1,
                   bus.cfg_prio0};

  function automatic logic [1:0] nxt(
    input logic [1:0] c
  );
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  // lowest priority value wins; ties go to the first
  // matching requester after the last granted channel
  always_comb begin
    min_p = 2'd3;
    for (int i = 0; i < 3; i++) begin
      if (req_v[i] && (prio_v[i] < min_p))
        min_p = prio_v[i];
    end
    win   = 2'd0;
    found = 1'b0;
    cand  = nxt(last_q);
    for (int k = 0; k < 3; k++) begin
      if (!found && req_v[cand] &&
          (prio_v[cand] == min_p)) begin
        win   = cand;
        found = 1'b1;
      end
      cand = nxt(cand);
    end
  end

  // datapath view of the granted channel
  always_comb begin
    g_req        = 1'b0;
    bus.fmt_data = 32'd0;
    case (grant_q)
      2'd0: begin
        g_req        = bus.ch0_req;
        bus.fmt_data = bus.ch0_data;
      end
      2'd1: begin
        g_req        = bus.ch1_req;
        bus.fmt_data = bus.ch1_data;
      end
      default: begin
        g_req        = bus.ch2_req;
        bus.fmt_data = bus.ch2_data;
      end
    endcase
  end

  assign last_beat = (6'd4 << len_q) - 6'd1;
  assign val       = (state_q == XFER) && g_req;
  assign beat      = val && bus.fmt_rdy;

  assign bus.fmt_val = val;
  assign bus.fmt_id  = grant_q;
  assign bus.fmt_sop = val && (cnt_q == 6'd0);
  assign bus.fmt_eop = val && (cnt_q == last_beat);
  assign bus.ch0_ack = beat && (grant_q == 2'd0);
  assign bus.ch1_ack = beat && (grant_q == 2'd1);
  assign bus.ch2_ack = beat && (grant_q == 2'd2);

  // grant in IDLE, count beats in XFER, leave on eop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 2'd0;
      last_q  <= 2'd2;
      len_q   <= 2'd0;
      cnt_q   <= 6'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|req_v) begin
            state_q <= XFER;
            grant_q <= win;
            last_q  <= win;
            len_q   <= bus.cfg_len;
            cnt_q   <= 6'd0;
          end
        end
        default: begin
          if (beat) begin
            if (cnt_q == last_beat) begin
              state_q <= IDLE;
              cnt_q   <= 6'd0;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcdf_arbiter.sv
// Testbench for mcdf_arbiter.
// Vector table plus corner-case sequences, queue scoreboard.
module tb_mcdf_arbiter;

  logic clk;
  logic rst;
  mcdf_arbiter_if bus ();

  mcdf_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  typedef struct {
    logic [2:0] req;
    logic [1:0] p0;
    logic [1:0] p1;
    logic [1:0] p2;
    logic [1:0] len;
    logic [1:0] exp_id;
  } vec_t;

  beat_t exp_q[$];
  int    beat_cyc[$];
  int    sop_cyc[$];
  int    checks;
  int    errors;
  int    cyc;
  int    nbeats;
  int    wcnt[3];
  int    exp_idx[3];
  vec_t  tbl[7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // producers: word index advances on each ack
  always @(posedge clk) begin
    if (bus.ch0_ack) wcnt[0] <= wcnt[0] + 1;
    if (bus.ch1_ack) wcnt[1] <= wcnt[1] + 1;
    if (bus.ch2_ack) wcnt[2] <= wcnt[2] + 1;
  end

  assign bus.ch0_data = {8'hA0, wcnt[0][23:0]};
  assign bus.ch1_data = {8'hA1, wcnt[1][23:0]};
  assign bus.ch2_data = {8'hA2, wcnt[2][23:0]};

  function automatic logic [7:0] base(
    input logic [1:0] id
  );
    return 8'hA0 + {6'd0, id};
  endfunction

  task automatic chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h",
               name, act, exp);
    end
  endtask

  task automatic push_beats(
    input logic [1:0] id,
    input int         n,
    input int         total
  );
    beat_t e;
    for (int k = 0; k < n; k++) begin
      e.id   = id;
      e.data = {base(id), exp_idx[id][23:0]};
      e.sop  = (k == 0);
      e.eop  = (k == total - 1);
      exp_idx[id]++;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_until_empty(
    input int budget,
    input bit tog
  );
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      if (tog) bus.fmt_rdy = ~bus.fmt_rdy;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout left %0d want 0",
               exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_beats(
    input int target,
    input int budget
  );
    int n;
    n = 0;
    while (nbeats < target && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (nbeats < target) begin
      checks++;
      errors++;
      $display("FAIL wait_beats got %0d want %0d",
               nbeats, target);
    end
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_val"}, 64'(bus.fmt_val), 64'd0);
    chk({name, "_sop"}, 64'(bus.fmt_sop), 64'd0);
    chk({name, "_eop"}, 64'(bus.fmt_eop), 64'd0);
    chk({name, "_id"}, 64'(bus.fmt_id), 64'd0);
    chk({name, "_ack"},
        64'({bus.ch2_ack, bus.ch1_ack, bus.ch0_ack}),
        64'd0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    #1;
    chk_quiet("rst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_req(input logic [2:0] r);
    bus.ch0_req = r[0];
    bus.ch1_req = r[1];
    bus.ch2_req = r[2];
  endtask

  task automatic set_prio(
    input logic [1:0] a,
    input logic [1:0] b,
    input logic [1:0] c
  );
    bus.cfg_prio0 = a;
    bus.cfg_prio1 = b;
    bus.cfg_prio2 = c;
  endtask

  // monitor: pop expected beat on every handshake
  initial begin
    beat_t       e;
    logic [2:0]  ackv;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        ackv = {bus.ch2_ack, bus.ch1_ack, bus.ch0_ack};
        if (bus.fmt_val && bus.fmt_rdy) begin
          nbeats++;
          beat_cyc.push_back(cyc);
          if (bus.fmt_sop) sop_cyc.push_back(cyc);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_beat id %0d data %h want none",
                     bus.fmt_id, bus.fmt_data);
          end else begin
            e = exp_q.pop_front();
            if ({bus.fmt_id, bus.fmt_data,
                 bus.fmt_sop, bus.fmt_eop} !== e) begin
              errors++;
              $display("FAIL beat id %0d data %h sop %b eop %b want id %0d data %h sop %b eop %b",
                       bus.fmt_id, bus.fmt_data,
                       bus.fmt_sop, bus.fmt_eop,
                       e.id, e.data, e.sop, e.eop);
            end
            checks++;
            if (ackv !== (3'b001 << e.id)) begin
              errors++;
              $display("FAIL ack got %b want %b",
                       ackv, 3'b001 << e.id);
            end
          end
        end else begin
          checks++;
          if (ackv !== 3'b000) begin
            errors++;
            $display("FAIL idle_ack got %b want 000",
                     ackv);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    nbeats = 0;
    for (int i = 0; i < 3; i++) begin
      wcnt[i]    = 0;
      exp_idx[i] = 0;
    end
    rst = 1'b1;
    set_req(3'b000);
    set_prio(2'd0, 2'd0, 2'd0);
    bus.cfg_len = 2'd0;
    bus.fmt_rdy = 1'b1;

    //         req     p0  p1  p2  len id
    tbl[0] = '{3'b010, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    tbl[1] = '{3'b111, 2'd2, 2'd1, 2'd3, 2'd0, 2'd1};
    tbl[2] = '{3'b111, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    tbl[3] = '{3'b110, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1};
    tbl[4] = '{3'b101, 2'd3, 2'd0, 2'd0, 2'd0, 2'd2};
    tbl[5] = '{3'b111, 2'd1, 2'd1, 2'd0, 2'd0, 2'd2};
    tbl[6] = '{3'b011, 2'd2, 2'd2, 2'd0, 2'd1, 2'd0};

    for (int t = 0; t < 7; t++) begin
      do_reset();
      set_prio(tbl[t].p0, tbl[t].p1, tbl[t].p2);
      bus.cfg_len = tbl[t].len;
      set_req(tbl[t].req);
      push_beats(tbl[t].exp_id,
                 4 << tbl[t].len, 4 << tbl[t].len);
      run_until_empty(200, 1'b0);
      set_req(3'b000);
      @(posedge clk);
      #1;
    end

    // single channel, back-to-back packets
    do_reset();
    set_prio(2'd0, 2'd0, 2'd0);
    bus.cfg_len = 2'd0;
    sop_cyc.delete();
    set_req(3'b010);
    push_beats(2'd1, 4, 4);
    push_beats(2'd1, 4, 4);
    run_until_empty(100, 1'b0);
    set_req(3'b000);
    chk("sop_count", 64'(sop_cyc.size()), 64'd2);
    if (sop_cyc.size() == 2)
      chk("sop_gap", 64'(sop_cyc[1] - sop_cyc[0]),
          64'd5);
    @(posedge clk);
    #1;

    // priority order with channels dropping out
    do_reset();
    set_prio(2'd2, 2'd1, 2'd3);
    set_req(3'b111);
    push_beats(2'd1, 4, 4);
    run_until_empty(100, 1'b0);
    bus.ch1_req = 1'b0;
    push_beats(2'd0, 4, 4);
    run_until_empty(100, 1'b0);
    bus.ch0_req = 1'b0;
    push_beats(2'd2, 4, 4);
    run_until_empty(100, 1'b0);
    set_req(3'b000);
    @(posedge clk);
    #1;

    // round-robin ties across four packets
    do_reset();
    set_prio(2'd0, 2'd0, 2'd0);
    bus.cfg_len = 2'd0;
    set_req(3'b111);
    push_beats(2'd0, 4, 4);
    push_beats(2'd1, 4, 4);
    push_beats(2'd2, 4, 4);
    push_beats(2'd0, 4, 4);
    run_until_empty(200, 1'b0);
    set_req(3'b000);
    @(posedge clk);
    #1;

    // backpressure with rdy toggling every cycle
    do_reset();
    bus.cfg_len = 2'd1;
    bus.fmt_rdy = 1'b1;
    beat_cyc.delete();
    set_req(3'b100);
    push_beats(2'd2, 8, 8);
    run_until_empty(100, 1'b1);
    set_req(3'b000);
    bus.fmt_rdy = 1'b1;
    chk("bp_beats", 64'(beat_cyc.size()), 64'd8);
    if (beat_cyc.size() == 8)
      chk("bp_span", 64'(beat_cyc[7] - beat_cyc[0]),
          64'd14);
    @(posedge clk);
    #1;

    // mid-packet req drop and config changes
    do_reset();
    bus.cfg_len = 2'd0;
    set_prio(2'd3, 2'd0, 2'd0);
    nbeats = 0;
    set_req(3'b001);
    push_beats(2'd0, 4, 4);
    wait_beats(1, 50);
    bus.cfg_len = 2'd3;
    set_prio(2'd0, 2'd3, 2'd3);
    wait_beats(3, 50);
    bus.ch0_req = 1'b0;
    bus.ch1_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_val", 64'(bus.fmt_val), 64'd0);
      chk("stall_id", 64'(bus.fmt_id), 64'd0);
      @(posedge clk);
      #1;
    end
    bus.ch0_req = 1'b1;
    run_until_empty(50, 1'b0);
    set_req(3'b000);
    chk("mid_beats", 64'(nbeats), 64'd4);
    bus.cfg_len = 2'd0;
    @(posedge clk);
    #1;

    // reset mid-packet, then restart from ch0
    do_reset();
    set_prio(2'd1, 2'd1, 2'd1);
    bus.cfg_len = 2'd1;
    nbeats = 0;
    set_req(3'b111);
    push_beats(2'd0, 5, 8);
    wait_beats(5, 50);
    chk("pre_rst_val", 64'(bus.fmt_val), 64'd1);
    rst = 1'b1;
    #1;
    chk_quiet("async_rst");
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_beats(2'd0, 8, 8);
    run_until_empty(100, 1'b0);
    set_req(3'b000);
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcdf_arbiter.md
MCDF_ARBITER -- requirements
Module: mcdf_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset; asserting it forces reset state immediately, independent of clk.
REQ-003 SHALL have ports ch0_req, ch1_req, ch2_req, input, 1 bit each: channel N holds a valid data word.
REQ-004 SHALL have ports ch0_data, ch1_data, ch2_data, input, 32 bits each: channel N data word.
REQ-005 SHALL have ports ch0_ack, ch1_ack, ch2_ack, output, 1 bit each: channel N word consumed this cycle.
REQ-006 SHALL have ports cfg_prio0, cfg_prio1, cfg_prio2, input, 2 bits each: channel N priority; lower value means higher priority.
REQ-007 SHALL have port cfg_len, input, 2 bits: packet length code; 0 = 4 words, 1 = 8 words, 2 = 16 words, 3 = 32 words.
REQ-008 SHALL have port fmt_rdy, input, 1 bit: downstream formatter accepts a word.
REQ-009 SHALL have port fmt_val, output, 1 bit: fmt_data is valid.
REQ-010 SHALL have port fmt_data, output, 32 bits: forwarded word.
REQ-011 SHALL have port fmt_id, output, 2 bits: granted channel number (0..2).
REQ-012 SHALL have port fmt_sop, output, 1 bit: first word of packet.
REQ-013 SHALL have port fmt_eop, output, 1 bit: last word of packet.

Function
REQ-014 SHALL implement two states: IDLE and XFER.
REQ-015 In IDLE with at least one chN_req high, SHALL select a winner, register the grant, latch cfg_len and enter XFER on the next clk edge.
REQ-016 In IDLE with no request, SHALL remain in IDLE.
REQ-017 Winner selection SHALL pick the requester with the numerically lowest cfg_prioN.
REQ-018 Priority ties SHALL be resolved round-robin, starting from the channel after the last granted one (order 0 -> 1 -> 2 -> 0).
REQ-019 The round-robin pointer SHALL update only when a grant is issued.
REQ-020 fmt_val SHALL equal (state == XFER) AND req of the granted channel; it SHALL be 0 in IDLE.
REQ-021 fmt_data SHALL combinationally mux the granted channel's data.
REQ-022 fmt_id SHALL hold the registered granted channel number throughout XFER.
REQ-023 A beat SHALL occur when fmt_val AND fmt_rdy are both high.
REQ-024 On each beat, the granted channel's ack SHALL be high for that cycle; all other acks SHALL be 0.
REQ-025 A beat counter (6 bits) SHALL count beats within the packet.
REQ-026 fmt_sop SHALL be high with fmt_val while the count is 0.
REQ-027 fmt_eop SHALL be high with fmt_val while the count equals the latched length minus 1.
REQ-028 The beat with fmt_eop high SHALL return the state to IDLE and clear the counter, giving exactly one bubble cycle before the next packet.
REQ-029 If the granted chN_req drops mid-packet, the arbiter SHALL stall in XFER with fmt_val = 0, with no timeout and no re-arbitration.
REQ-030 If fmt_rdy is low, the arbiter SHALL stall: counter held, no ack.
REQ-031 Changes to cfg_prioN and cfg_len during XFER SHALL NOT affect the current packet.
REQ-032 Requests from non-granted channels during XFER SHALL be ignored until IDLE.
REQ-033 Only one ack SHALL ever be high in a cycle.

Reset
REQ-034 While rst is high: state = IDLE, counter = 0, last-granted = 2 (so channel 0 wins the first tie), latched length = 4.
REQ-035 While rst is high: fmt_val, fmt_sop, fmt_eop, all acks = 0, and fmt_id = 0.
REQ-036 Reset asserted mid-packet SHALL abort the packet immediately with no eop.
REQ-037 After reset deasserts, the arbiter SHALL re-arbitrate from IDLE.

Verification
REQ-038 Single channel: ch1_req = 1 continuously, cfg_len = 0, fmt_rdy = 1 -> 4 beats with fmt_id = 1; sop on beat 0, eop on beat 3; one idle cycle, then the next packet.
REQ-039 Priority: all req = 1, prio = {0: 2, 1: 1, 2: 3} -> ch1 granted first; after ch1 is dropped, ch0 is granted, then ch2.
REQ-040 Round-robin tie: all req = 1, all prio = 0, cfg_len = 0 -> grant order 0, 1, 2, 0 across four packets of 4 beats each.
REQ-041 Backpressure: fmt_rdy toggling 1, 0 each cycle, cfg_len = 1 -> 8 beats over 16 cycles; acks appear only on rdy-high cycles; data order preserved.
REQ-042 Mid-packet changes: ch0 drops req after beat 2 for 3 cycles, and cfg_len is changed to 3 at beat 1 -> fmt_val = 0 for 3 cycles, then the packet resumes and ends after 4 beats total.
REQ-043 Reset mid-packet: rst pulsed at beat 5 of 8 -> all outputs 0 asynchronously; after release, the first tie with all prio equal grants ch0 and restarts with sop.
